bpm_beat_generator: RTL and testbench

Downstream consumer of the BPM adjustment stage: accumulates each signed period delta (issued together with a one-cycle change strobe) into a clamped beat-period register. Runs a free-running cycle counter against that period to emit one-cycle beat pulses, a bar downbeat flag and the beat index within the bar. Its outputs drive the click/LED driver and the BPM display.

---
 rtl/metronome_pkg.sv | 34 +++
 rtl/bpm_beat_generator_if.sv | 34 +++
 rtl/bpm_period_reg.sv | 42 ++++
 rtl/bpm_beat_generator.sv | 111 +++++++++++
 tb/tb_bpm_beat_generator.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/metronome_pkg.sv
// Shared metronome types and constants: bus widths, default beat periods,
// beat FSM states and the period clamp helper.
package metronome_pkg;

    localparam int unsigned BPM_W      = 34;
    localparam int unsigned BEAT_IDX_W = 4;

    // Defaults for a 50 MHz system clock: 60 BPM at reset, 20..300 BPM range
    localparam logic [BPM_W-1:0] DEF_RESET_PERIOD = 34'd50_000_000;
    localparam logic [BPM_W-1:0] DEF_MIN_PERIOD   = 34'd10_000_000;
    localparam logic [BPM_W-1:0] DEF_MAX_PERIOD   = 34'd150_000_000;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } beat_state_e;

    // Clamp a signed 35-bit candidate period into [min_p, max_p]; negatives land on min_p
    function automatic logic [BPM_W-1:0] clamp_period(
        input logic signed [BPM_W:0] sum,
        input logic        [BPM_W-1:0] min_p,
        input logic        [BPM_W-1:0] max_p
    );
        if (sum < $signed({1'b0, min_p})) begin
            return min_p;
        end else if (sum > $signed({1'b0, max_p})) begin
            return max_p;
        end else begin
            return sum[BPM_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bpm_beat_generator_if.sv
// Control/status bundle between the BPM adjustment stage (master) and the
// beat generator (slave).
interface bpm_beat_generator_if;
    import metronome_pkg::*;

    logic [BPM_W-1:0]      i_bpm_counter_adder;
    logic                  i_bpm_changed;
    logic                  i_enable;
    logic [BPM_W-1:0]      o_period;
    logic                  o_beat;
    logic                  o_downbeat;
    logic [BEAT_IDX_W-1:0] o_beat_index;

    modport master (
        output i_bpm_counter_adder,
        output i_bpm_changed,
        output i_enable,
        input  o_period,
        input  o_beat,
        input  o_downbeat,
        input  o_beat_index
    );

    modport slave (
        input  i_bpm_counter_adder,
        input  i_bpm_changed,
        input  i_enable,
        output o_period,
        output o_beat,
        output o_downbeat,
        output o_beat_index
    );

endinterface

// File: rtl/bpm_period_reg.sv
// Beat-period register: accumulates signed period deltas on the change strobe
// and clamps the result into [MIN_PERIOD, MAX_PERIOD].
module bpm_period_reg
    import metronome_pkg::*;
#(
    parameter logic [BPM_W-1:0] RESET_PERIOD = DEF_RESET_PERIOD,
    parameter logic [BPM_W-1:0] MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter logic [BPM_W-1:0] MAX_PERIOD   = DEF_MAX_PERIOD
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_bpm_changed,
    input  logic [BPM_W-1:0] i_bpm_counter_adder,
    output logic [BPM_W-1:0] o_period
);

    logic [BPM_W-1:0]        period_q;
    logic [BPM_W-1:0]        period_d;
    logic signed [BPM_W:0]   sum_c;

    // Signed 35-bit accumulate of the current period and the sign-extended delta
    always_comb begin
        sum_c    = $signed({1'b0, period_q})
                 + $signed({i_bpm_counter_adder[BPM_W-1], i_bpm_counter_adder});
        period_d = period_q;
        if (i_bpm_changed) begin
            period_d = clamp_period(sum_c, MIN_PERIOD, MAX_PERIOD);
        end
    end

    // Period register, returns to the reset tempo asynchronously
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            period_q <= RESET_PERIOD;
        end else begin
            period_q <= period_d;
        end
    end

    assign o_period = period_q;

endmodule

// File: rtl/bpm_beat_generator.sv
// Metronome beat generator: free-running cycle counter compared against the
// clamped beat period, producing one-cycle beat pulses, a bar downbeat flag
// and the beat index within the bar.
// Optional feature macro BEAT_RESTART_ON_CHANGE_EN: an accepted period change
// while running restarts the beat phase (counter cleared, index kept).
module bpm_beat_generator
    import metronome_pkg::*;
#(
    parameter logic [BPM_W-1:0] RESET_PERIOD  = DEF_RESET_PERIOD,
    parameter logic [BPM_W-1:0] MIN_PERIOD    = DEF_MIN_PERIOD,
    parameter logic [BPM_W-1:0] MAX_PERIOD    = DEF_MAX_PERIOD,
    parameter int unsigned      BEATS_PER_BAR = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    bpm_beat_generator_if.slave  bus
);

    localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS_PER_BAR - 1);

    beat_state_e           state_q;
    logic [BPM_W-1:0]      period;
    logic [BPM_W-1:0]      cnt_q;
    logic                  beat_q;
    logic                  down_q;
    logic [BEAT_IDX_W-1:0] idx_q;
    logic                  wrap_c;
    logic [BEAT_IDX_W-1:0] idx_nxt_c;

    bpm_period_reg #(
        .RESET_PERIOD (RESET_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD),
        .MAX_PERIOD   (MAX_PERIOD)
    ) u_period_reg (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_bpm_changed       (bus.i_bpm_changed),
        .i_bpm_counter_adder (bus.i_bpm_counter_adder),
        .o_period            (period)
    );

    // >= rather than == so a shrink below the current count beats next cycle
    assign wrap_c    = (cnt_q >= period - BPM_W'(1));
    assign idx_nxt_c = (idx_q == LAST_IDX) ? '0 : idx_q + BEAT_IDX_W'(1);

    // Beat FSM with counter, index and registered pulse outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= STOP;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            down_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            beat_q <= 1'b0;
            down_q <= 1'b0;
            case (state_q)
                STOP: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (bus.i_enable) begin
                        // First downbeat is presented during the START cycle
                        state_q <= START;
                        beat_q  <= 1'b1;
                        down_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bus.i_enable) begin
                        cnt_q   <= BPM_W'(1);
                        state_q <= RUN;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                    end
                end
                RUN: begin
                    if (!bus.i_enable) begin
                        state_q <= STOP;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        if (wrap_c) begin
                            cnt_q  <= '0;
                            beat_q <= 1'b1;
                            down_q <= (idx_nxt_c == '0);
                            idx_q  <= idx_nxt_c;
                        end else begin
                            cnt_q <= cnt_q + BPM_W'(1);
                        end
`ifdef BEAT_RESTART_ON_CHANGE_EN
                        if (bus.i_bpm_changed) begin
                            cnt_q <= '0;
                        end
`else
`endif
                    end
                end
                default: begin
                    state_q <= STOP;
                end
            endcase
        end
    end

    assign bus.o_period     = period;
    assign bus.o_beat       = beat_q;
    assign bus.o_downbeat   = down_q;
    assign bus.o_beat_index = idx_q;

endmodule

// File: tb/tb_bpm_beat_generator.sv
// Scoreboard bench for bpm_beat_generator: a time-based reference model
// predicts beat times, bar positions and the period; a monitor compares
// every cycle. Honours BEAT_RESTART_ON_CHANGE_EN when defined.
module tb_bpm_beat_generator;
    import metronome_pkg::*;

    localparam longint RST_P = 20;
    localparam longint MIN_P = 10;
    localparam longint MAX_P = 40;
    localparam int     BPB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bpm_beat_generator_if bus();

    bpm_beat_generator #(
        .RESET_PERIOD  (34'd20),
        .MIN_PERIOD    (34'd10),
        .MAX_PERIOD    (34'd40),
        .BEATS_PER_BAR (BPB)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; bit down; } beat_t;
    typedef struct { int cyc; longint per; } per_t;

    beat_t beat_q[$];
    per_t  per_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Reference model: 0 stopped, 1 first-beat cycle, 2 running.
    // A beat appears in cycle b once b - m_last reaches the period seen in cycle b-1.
    int     m_state = 0;
    int     m_last  = 0;
    int     m_beats = 0;
    longint m_per   = RST_P;

    function automatic longint clampm(input longint s);
        if (s < MIN_P) return MIN_P;
        if (s > MAX_P) return MAX_P;
        return s;
    endfunction

    task automatic step(input bit en, input bit chg, input logic [33:0] add);
        longint nper;
        int     k;
        beat_t  b;
        per_t   p;
        @(negedge clk);
        #1;
        bus.i_enable            = en;
        bus.i_bpm_changed       = chg;
        bus.i_bpm_counter_adder = add;
        k    = cyc;
        nper = chg ? clampm(m_per + longint'($signed(add))) : m_per;
        case (m_state)
            0: begin
                if (en) begin
                    b.cyc = k + 1; b.idx = 0; b.down = 1'b1;
                    beat_q.push_back(b);
                    m_beats = 1;
                    m_last  = k + 1;
                    m_state = 1;
                end
            end
            1: m_state = en ? 2 : 0;
            default: begin
                if (!en) begin
                    m_state = 0;
                end else begin
                    if ((k + 1 - m_last) >= m_per) begin
                        b.cyc = k + 1; b.idx = m_beats % BPB; b.down = ((m_beats % BPB) == 0);
                        beat_q.push_back(b);
                        m_beats++;
                        m_last = k + 1;
                    end
`ifdef BEAT_RESTART_ON_CHANGE_EN
                    if (chg) m_last = k + 1;
`else
`endif
                end
            end
        endcase
        m_per = nper;
        p.cyc = k + 1; p.per = nper;
        per_q.push_back(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        bus.i_enable      = 1'b0;
        bus.i_bpm_changed = 1'b0;
        #1;
        check("reset_period",   bus.o_period == 34'd20, longint'(bus.o_period), RST_P);
        check("reset_beat",     bus.o_beat == 1'b0, longint'(bus.o_beat), 0);
        check("reset_downbeat", bus.o_downbeat == 1'b0, longint'(bus.o_downbeat), 0);
        check("reset_index",    bus.o_beat_index == 4'd0, longint'(bus.o_beat_index), 0);
        beat_q.delete();
        per_q.delete();
        m_state = 0; m_beats = 0; m_last = 0; m_per = RST_P;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares period every cycle and beat presence/position against the queues
    always @(negedge clk) begin
        per_t  pe;
        beat_t be;
        bit    exp_b;
        if (!rst) begin
            if (per_q.size() > 0 && per_q[0].cyc == cyc) begin
                pe = per_q.pop_front();
                check("period", longint'(bus.o_period) == pe.per, longint'(bus.o_period), pe.per);
            end
            exp_b = (beat_q.size() > 0 && beat_q[0].cyc == cyc);
            check("beat", bus.o_beat == exp_b, longint'(bus.o_beat), longint'(exp_b));
            if (exp_b) begin
                be = beat_q.pop_front();
                if (bus.o_beat) begin
                    check("beat_index", int'(bus.o_beat_index) == be.idx, longint'(bus.o_beat_index), be.idx);
                    check("downbeat", bus.o_downbeat == be.down, longint'(bus.o_downbeat), longint'(be.down));
                end
            end else begin
                check("downbeat_idle", bus.o_downbeat == 1'b0, longint'(bus.o_downbeat), 0);
            end
        end
    end

    logic [33:0] adds    [10];
    longint      exp_tab [10];

    initial begin
        bit          en_r;
        int          d;
        logic [33:0] a;
        adds    = '{34'd5, 34'h3_FFFF_FFFB, 34'h3_FFFF_FFFB, 34'h3_FFFF_FFFB, 34'h3_FFFF_FFFB,
                    34'd10, 34'd995, 34'h3_FFFF_FFFB, 34'h3_FFFF_FC18, 34'd10};
        exp_tab = '{25, 20, 15, 10, 10, 20, 40, 35, 10, 20};

        bus.i_enable            = 1'b0;
        bus.i_bpm_changed       = 1'b0;
        bus.i_bpm_counter_adder = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("init_period", bus.o_period == 34'd20, longint'(bus.o_period), RST_P);
        check("init_beat",   bus.o_beat == 1'b0, longint'(bus.o_beat), 0);
        check("init_index",  bus.o_beat_index == 4'd0, longint'(bus.o_beat_index), 0);
        #1;
        rst = 1'b0;

        // Steady tempo from reset: beats every 20 cycles, downbeat every 4th
        repeat (90) step(1'b1, 1'b0, '0);

        // Period accumulate and clamp sequence
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, adds[i]);
            step(1'b1, 1'b0, '0);
            check("period_table", longint'(bus.o_period) == exp_tab[i], longint'(bus.o_period), exp_tab[i]);
            repeat (6) step(1'b1, 1'b0, '0);
        end

        // Shrink period 20 -> 15 while the counter sits at 18
        for (int n = 0; n < 100 && !(m_state == 2 && (cyc + 1 - m_last) == 18); n++)
            step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 34'h3_FFFF_FFFB);
        repeat (40) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 34'd5);
        repeat (10) step(1'b1, 1'b0, '0);

        // Stop mid-bar right after beat index 2, then restart
        for (int n = 0; n < 200 && !(m_state == 2 && m_last == cyc + 1 && (m_beats % BPB) == 3); n++)
            step(1'b1, 1'b0, '0);
        repeat (5) step(1'b1, 1'b0, '0);
        repeat (10) step(1'b0, 1'b0, '0);
        check("index_stopped", bus.o_beat_index == 4'd0, longint'(bus.o_beat_index), 0);
        repeat (50) step(1'b1, 1'b0, '0);

        // Restart-phase check point: strobe at counter 7
        for (int n = 0; n < 100 && !(m_state == 2 && (cyc + 1 - m_last) == 7); n++)
            step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 34'd3);
        repeat (50) step(1'b1, 1'b0, '0);

        // Asynchronous reset mid-count with period 30
        step(1'b1, 1'b1, 34'd7);
        repeat (37) step(1'b1, 1'b0, '0);
        do_reset();
        repeat (5) step(1'b0, 1'b0, '0);

        // Randomised enables and period deltas
        en_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (en_r && $urandom_range(0, 149) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 9) == 0) en_r = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                a = 34'({$urandom(), $urandom()});
            end else begin
                d = int'($urandom_range(0, 40)) - 20;
                a = 34'(d);
            end
            step(en_r, ($urandom_range(0, 24) == 0), a);
        end

        repeat (5) step(1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("queue_drained", beat_q.size() == 0, longint'(beat_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
